// File: rtl/kd_tree_pkg.sv
// Shared kd-tree constants: word widths, the tree command codes and the loader FSM states.
package kd_tree_pkg;

  localparam int DATA_SIZE    = 24;
  localparam int COMMAND_SIZE = 5;

  localparam logic [COMMAND_SIZE-1:0] CMD_NOP                       = 5'b00000;
  localparam logic [COMMAND_SIZE-1:0] CMD_RST                       = 5'b11111;
  localparam logic [COMMAND_SIZE-1:0] CMD_RST_DONE                  = 5'b11110;
  localparam logic [COMMAND_SIZE-1:0] CMD_CENTER_FILL               = 5'b00001;
  localparam logic [COMMAND_SIZE-1:0] CMD_CONFIGURE_SORT_AXIS       = 5'b00010;
  localparam logic [COMMAND_SIZE-1:0] CMD_CENTER_FILL_DONE          = 5'b00101;
  localparam logic [COMMAND_SIZE-1:0] CMD_CONFIGURE_SORT_AXIS_DONE  = 5'b00111;
  localparam logic [COMMAND_SIZE-1:0] CMD_BUSY                      = 5'b01000;

  typedef enum logic [2:0] {
    IDLE,
    TREE_RST,
    FILL,
    FILL_WAIT,
    AXIS,
    DONE
  } loader_state_t;

  // States that block on an acknowledge from the root and are therefore timed.
  function automatic logic is_wait_state(input loader_state_t s);
    return (s == TREE_RST) || (s == FILL_WAIT) || (s == AXIS);
  endfunction

endpackage

// File: rtl/kd_tree_loader_if.sv
// Center source stream plus the root node's top command/data port.
interface kd_tree_loader_if
  import kd_tree_pkg::*;
;
  logic [DATA_SIZE-1:0]    in_data;
  logic                    in_valid;
  logic                    in_ready;
  logic [COMMAND_SIZE-1:0] command_to_root;
  logic [DATA_SIZE-1:0]    data_to_root;
  logic [COMMAND_SIZE-1:0] command_from_root;

  modport master (
    input  in_data, in_valid, command_from_root,
    output in_ready, command_to_root, data_to_root
  );

  modport slave (
    output in_data, in_valid, command_from_root,
    input  in_ready, command_to_root, data_to_root
  );
endinterface

// File: rtl/kd_wait_timer.sv
// Acknowledge-wait counter: restarts on clear, flags the last allowed cycle while enabled.
module kd_wait_timer #(
  parameter int unsigned WAIT_LIMIT = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int unsigned CW = (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT + 1);

  logic [CW-1:0] wait_cnt;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wait_cnt <= '0;
    end else if (enable) begin
      wait_cnt <= wait_cnt + CW'(1);
    end
  end

  // The edge that would complete cycle WAIT_LIMIT is the expiry edge.
  assign expired = enable && (wait_cnt == CW'(WAIT_LIMIT - 1));

endmodule

// File: rtl/kd_tree_loader.sv
// Host-side sequencer for the kd-tree root: reset, center fill, sort-axis configuration,
// each step gated by the root's acknowledge with a per-wait timeout.
module kd_tree_loader
  import kd_tree_pkg::*;
#(
  parameter int unsigned MAX_CENTERS = 16,
  parameter int unsigned WAIT_LIMIT  = 1024
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start,
  input  logic [$clog2(MAX_CENTERS+1)-1:0]   num_centers,
  kd_tree_loader_if.master                   bus,
  output logic                               busy,
  output logic                               done,
  output logic                               error
);
  localparam int unsigned CW = $clog2(MAX_CENTERS + 1);

  loader_state_t state, state_next;

  logic [CW-1:0]           count;
  logic [CW-1:0]           sent;
  logic [COMMAND_SIZE-1:0] cmd_q, cmd_next;
  logic [DATA_SIZE-1:0]    data_q;
  logic                    start_ok;
  logic                    beat;
  logic                    ack;
  logic                    expired;
  logic                    timeout;

  assign start_ok     = (num_centers != '0) && (num_centers <= CW'(MAX_CENTERS));
  assign bus.in_ready = (state == FILL) && (bus.command_from_root != CMD_BUSY) && (sent < count);
  assign beat         = bus.in_ready && bus.in_valid;

  assign busy                = (state != IDLE);
  assign done                = (state == DONE);
  assign bus.command_to_root = cmd_q;
  assign bus.data_to_root    = data_q;

  kd_wait_timer #(
    .WAIT_LIMIT (WAIT_LIMIT)
  ) u_wait_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (state_next != state),
    .enable  (is_wait_state(state)),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    ack        = 1'b0;
    timeout    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start && start_ok) begin
          state_next = TREE_RST;
        end
      end
      TREE_RST: begin
        ack = (bus.command_from_root == CMD_RST_DONE);
        if (ack) begin
          state_next = FILL;
        end
      end
      FILL: begin
        if (beat && ((sent + CW'(1)) == count)) begin
          state_next = FILL_WAIT;
        end
      end
      FILL_WAIT: begin
        ack = (bus.command_from_root == CMD_CENTER_FILL_DONE);
        if (ack) begin
          state_next = AXIS;
        end
      end
      AXIS: begin
        ack = (bus.command_from_root == CMD_CONFIGURE_SORT_AXIS_DONE);
        if (ack) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // An acknowledge on the expiry edge still counts as progress.
    if (expired && !ack) begin
      timeout    = 1'b1;
      state_next = IDLE;
    end
  end

  // Command register is loaded from the upcoming state so an acknowledge retargets it on the same edge.
  always_comb begin
    cmd_next = CMD_NOP;
    if (beat) begin
      cmd_next = CMD_CENTER_FILL;
    end else begin
      unique case (state_next)
        TREE_RST: cmd_next = CMD_RST;
        AXIS:     cmd_next = CMD_CONFIGURE_SORT_AXIS;
        default:  cmd_next = CMD_NOP;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_q  <= CMD_NOP;
      data_q <= '0;
      count  <= '0;
      sent   <= '0;
      error  <= 1'b0;
    end else begin
      cmd_q <= cmd_next;
      if (beat) begin
        data_q <= bus.in_data;
        sent   <= sent + CW'(1);
      end
      if ((state == IDLE) && start) begin
        if (start_ok) begin
          count <= num_centers;
          sent  <= '0;
          error <= 1'b0;
        end else begin
          error <= 1'b1;
        end
      end
      if (timeout) begin
        error <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_kd_tree_loader.sv
// Randomized bench for kd_tree_loader: behavioural root model, source stream and scoreboard monitor.
module tb_kd_tree_loader;
  import kd_tree_pkg::*;

  localparam int unsigned MAXC = 16;
  localparam int unsigned WLIM = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [4:0] num_centers;
  logic       busy, done, error;

  kd_tree_loader_if bus ();

  kd_tree_loader #(
    .MAX_CENTERS (MAXC),
    .WAIT_LIMIT  (WLIM)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .num_centers (num_centers),
    .bus         (bus),
    .busy        (busy),
    .done        (done),
    .error       (error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Scoreboard queues: centers expected at the root, and expected error flag per done pulse.
  logic [DATA_SIZE-1:0] exp_q[$];
  logic                 res_q[$];
  logic [DATA_SIZE-1:0] src_q[$];

  // Root model knobs
  bit answer_rst  = 1'b1;
  int rst_delay   = 1;
  int fill_delay  = 1;
  int axis_delay  = 1;
  int root_expect = 0;
  int busy_after  = 0;
  int busy_len    = 0;

  int rst_cnt = 0, beats = 0, fw_cnt = 0, ax_cnt = 0, busy_left = 0;
  logic [COMMAND_SIZE-1:0] root_nxt;
  logic busy_at_edge = 1'b0;

  // Behavioural root: acknowledges each phase some cycles after seeing its command.
  always @(negedge clk) begin
    if (reset) begin
      rst_cnt = 0; beats = 0; fw_cnt = 0; ax_cnt = 0; busy_left = 0;
      bus.command_from_root = CMD_NOP;
    end else begin
      root_nxt = CMD_NOP;
      if (bus.command_to_root == CMD_RST) begin
        rst_cnt++; beats = 0; fw_cnt = 0;
        if (answer_rst && rst_cnt >= rst_delay) root_nxt = CMD_RST_DONE;
      end else begin
        rst_cnt = 0;
      end
      if (bus.command_to_root == CMD_CENTER_FILL) begin
        beats++;
        if (beats == busy_after) busy_left = busy_len;
      end
      if (bus.command_to_root == CMD_CONFIGURE_SORT_AXIS) begin
        ax_cnt++; beats = 0; fw_cnt = 0;
        if (ax_cnt >= axis_delay) root_nxt = CMD_CONFIGURE_SORT_AXIS_DONE;
      end else begin
        ax_cnt = 0;
      end
      if (bus.command_to_root == CMD_NOP && beats > 0 && beats == root_expect) begin
        fw_cnt++;
        if (fw_cnt >= fill_delay) root_nxt = CMD_CENTER_FILL_DONE;
      end
      if (busy_left > 0 && root_nxt == CMD_NOP) begin
        root_nxt = CMD_BUSY;
        busy_left--;
      end
      bus.command_from_root = root_nxt;
    end
  end

  always @(posedge clk) busy_at_edge <= (bus.command_from_root == CMD_BUSY);

  // Source stream
  int   vmode   = 0;
  bit   tog     = 1'b0;
  bit   src_acc = 1'b0;

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    forever begin
      @(negedge clk);
      if (src_acc && src_q.size() > 0) void'(src_q.pop_front());
      src_acc = 1'b0;
      tog = ~tog;
      if (src_q.size() > 0) begin
        case (vmode)
          0:       bus.in_valid = 1'b1;
          1:       bus.in_valid = tog;
          default: bus.in_valid = ($urandom_range(0, 99) < 60);
        endcase
        bus.in_data = src_q[0];
      end else begin
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
      end
      #3;
      if (bus.command_from_root == CMD_BUSY) check("in_ready_while_root_busy", bus.in_ready, 0);
      if (!busy) check("in_ready_while_idle", bus.in_ready, 0);
      src_acc = bus.in_valid && bus.in_ready && !reset;
    end
  end

  // Monitor
  bit expect_rst_first = 1'b0;
  bit cfg_seen         = 1'b0;
  int fill_seen        = 0;
  int runs_done        = 0;
  logic exp_err;

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.command_to_root != CMD_NOP && expect_rst_first) begin
        check("first_command_is_rst", bus.command_to_root, CMD_RST);
        expect_rst_first = 1'b0;
      end
      if (bus.command_to_root == CMD_CENTER_FILL) begin
        fill_seen++;
        check("no_fill_while_root_busy", busy_at_edge, 0);
        if (exp_q.size() > 0) check("center_data", bus.data_to_root, exp_q.pop_front());
        else check("center_extra", bus.command_to_root, CMD_NOP);
      end
      if (bus.command_to_root == CMD_CONFIGURE_SORT_AXIS) begin
        if (!cfg_seen) check("axis_after_all_centers", exp_q.size(), 0);
        cfg_seen = 1'b1;
      end
      if (done) begin
        if (res_q.size() > 0) begin
          exp_err = res_q.pop_front();
          check("done_error_flag", error, exp_err);
          check("done_after_axis", cfg_seen, 1);
          check("done_command_nop", bus.command_to_root, CMD_NOP);
        end else begin
          check("unexpected_done", done, 0);
        end
        cfg_seen = 1'b0;
        runs_done++;
      end
    end
  end

  logic [DATA_SIZE-1:0] fixed_w[3] = '{24'hFF0000, 24'h00FF00, 24'h0000FF};

  task automatic do_run(input int n, input int vm, input int rd, input int fd, input int ad,
                        input int ba, input int bl, input bit use_fixed);
    logic [DATA_SIZE-1:0] w;
    int d0, cyc;
    answer_rst = 1'b1; rst_delay = rd; fill_delay = fd; axis_delay = ad;
    busy_after = ba; busy_len = bl; root_expect = n; vmode = vm; tog = 1'b0;
    fill_seen = 0; expect_rst_first = 1'b1; cfg_seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      w = use_fixed ? fixed_w[i % 3] : DATA_SIZE'($urandom);
      src_q.push_back(w);
      exp_q.push_back(w);
    end
    res_q.push_back(1'b0);
    @(negedge clk); start = 1'b1; num_centers = 5'(n);
    @(negedge clk); start = 1'b0; #1;
    check("start_clears_error", error, 0);
    check("busy_after_start", busy, 1);
    d0 = runs_done; cyc = 0;
    while (runs_done == d0 && cyc < 2000) begin
      @(negedge clk); #1; cyc++;
    end
    check("run_completed_once", runs_done - d0, 1);
    check("centers_drained", exp_q.size(), 0);
    check("center_fill_count", fill_seen, n);
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    @(negedge clk); reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; num_centers = '0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_error", error, 0);
    check("reset_command", bus.command_to_root, CMD_NOP);
    check("reset_data", bus.data_to_root, 0);
    check("reset_in_ready", bus.in_ready, 0);
    reset = 1'b0;

    do_run(3, 0, 4, 2, 3, 0, 0, 1'b1);
    do_run(3, 1, 4, 2, 3, 0, 0, 1'b1);
    do_run(5, 0, 3, 2, 3, 2, 2, 1'b0);
    for (int r = 0; r < 8; r++) begin
      int n;
      n = $urandom_range(1, 16);
      do_run(n, $urandom_range(0, 2), $urandom_range(1, 6), $urandom_range(1, 6),
             $urandom_range(1, 6), (n > 1) ? $urandom_range(0, n - 1) : 0,
             $urandom_range(1, 3), 1'b0);
    end

    // Root never acknowledges reset
    answer_rst = 1'b0; expect_rst_first = 1'b1; root_expect = 3;
    @(negedge clk); start = 1'b1; num_centers = 5'd3;
    @(negedge clk); start = 1'b0; #1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk); #1;
      if (k == 15) begin
        check("timeout_not_early_busy", busy, 1);
        check("timeout_not_early_error", error, 0);
      end
      if (k == 16) begin
        check("timeout_error", error, 1);
        check("timeout_idle", busy, 0);
        check("timeout_command_nop", bus.command_to_root, CMD_NOP);
      end
    end
    do_run(2, 0, 2, 1, 1, 0, 0, 1'b0);

    // Out-of-range counts
    for (int t = 0; t < 2; t++) begin
      pulse_reset();
      check("pre_illegal_error", error, 0);
      @(negedge clk); start = 1'b1; num_centers = (t == 0) ? 5'd0 : 5'd17;
      @(negedge clk); start = 1'b0;
      for (int k = 0; k < 4; k++) begin
        #1;
        check("illegal_start_error", error, 1);
        check("illegal_start_busy", busy, 0);
        check("illegal_start_command", bus.command_to_root, CMD_NOP);
        @(negedge clk);
      end
    end

    // Reset in the middle of a fill
    begin
      int cyc;
      answer_rst = 1'b1; rst_delay = 2; fill_delay = 1; axis_delay = 1;
      busy_after = 0; busy_len = 0; root_expect = 5; vmode = 0;
      fill_seen = 0; expect_rst_first = 1'b1;
      for (int i = 0; i < 5; i++) begin
        src_q.push_back(DATA_SIZE'($urandom));
        exp_q.push_back(src_q[i]);
      end
      @(negedge clk); start = 1'b1; num_centers = 5'd5;
      @(negedge clk); start = 1'b0;
      cyc = 0;
      while (fill_seen < 2 && cyc < 200) begin
        @(negedge clk); #1; cyc++;
      end
      check("mid_fill_two_centers", fill_seen, 2);
      reset = 1'b1;
      @(negedge clk); #1;
      check("mid_fill_reset_command", bus.command_to_root, CMD_NOP);
      check("mid_fill_reset_busy", busy, 0);
      src_q.delete(); exp_q.delete(); res_q.delete();
      reset = 1'b0;
      do_run(4, 2, 3, 2, 2, 0, 0, 1'b0);
    end

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
